// File: rtl/bc_stage_if_prefetch.sv
// BureCore fetch stage: keeps up to DEPTH imem requests outstanding, buffers
// returned instructions with their PCs, and hands them to decode over valid/ready.
module bc_stage_if_prefetch #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           PC_STEP     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic [ADDR_WIDTH-1:0]  o_imem_raddr,
  output logic                   o_imem_raddr_valid,
  input  logic                   i_imem_raddr_ready,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  input  logic                   i_imem_rdata_valid,
  output logic                   o_imem_rdata_ready,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 2;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready of the same channel.

  // RUN accepts responses; DRAIN drops responses that predate a redirect.
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CW-1:0]          discard_q, discard_d;
  logic [CW-1:0]          fifo_count_q, fifo_count_d;
  logic [PW-1:0]          fifo_wr_q, fifo_rd_q;
  logic [PW-1:0]          tag_wr_q, tag_rd_q;
  logic [ADDR_WIDTH-1:0]  tag_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc [DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_instr [DEPTH];

  logic [SW-1:0] used;
  logic          issue;
  logic          accept;
  logic          drop;
  logic          pop;

  // Outstanding discards still hold memory slots, so they count against credit.
  assign used               = SW'(inflight_q) + SW'(discard_q) + SW'(fifo_count_q);
  assign o_imem_raddr_valid = !i_rst && !i_redirect && (used < SW'(DEPTH));
  assign o_imem_raddr       = pc_q;
  assign o_imem_rdata_ready = 1'b1;

  assign issue  = o_imem_raddr_valid && i_imem_raddr_ready;
  assign accept = i_imem_rdata_valid && !i_redirect && (state_q == RUN);
  assign drop   = i_imem_rdata_valid && !i_redirect && (state_q == DRAIN);

  assign o_instr_valid = (fifo_count_q != '0);
  assign o_instr       = fifo_instr[fifo_rd_q];
  assign o_instr_pc    = fifo_pc[fifo_rd_q];
  assign pop           = o_instr_valid && i_instr_ready && !i_redirect;

  always_comb begin
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    discard_d    = discard_q;
    fifo_count_d = fifo_count_q;
    if (i_redirect) begin
      // Everything still in flight becomes stale; a response arriving now is one of them.
      pc_d         = i_redirect_pc;
      inflight_d   = '0;
      discard_d    = discard_q + inflight_q - (i_imem_rdata_valid ? CW'(1) : CW'(0));
      fifo_count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
      inflight_d   = inflight_q + CW'(issue) - CW'(accept);
      discard_d    = discard_q - CW'(drop);
      fifo_count_d = fifo_count_q + CW'(accept) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    if (discard_d != '0) state_d = DRAIN;
    else                 state_d = RUN;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= '0;
      discard_q    <= '0;
      fifo_count_q <= '0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      fifo_count_q <= fifo_count_d;
      if (i_redirect) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
        tag_wr_q  <= '0;
        tag_rd_q  <= '0;
      end else begin
        if (issue) tag_wr_q <= tag_wr_q + PW'(1);
        if (accept) begin
          tag_rd_q  <= tag_rd_q + PW'(1);
          fifo_wr_q <= fifo_wr_q + PW'(1);
        end
        if (pop) fifo_rd_q <= fifo_rd_q + PW'(1);
      end
    end
  end

  // Storage arrays need no reset: the pointers and counts define what is live.
  always_ff @(posedge i_clk) begin
    if (issue) tag_mem[tag_wr_q] <= pc_q;
    if (accept) begin
      fifo_pc[fifo_wr_q]    <= tag_mem[tag_rd_q];
      fifo_instr[fifo_wr_q] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_bc_stage_if_prefetch.sv
// Bench for bc_stage_if_prefetch: directed vector table, hand-written corner
// sequences and a randomized run against an epoch-based reference model.
module tb_bc_stage_if_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_imem_raddr;
  logic        o_imem_raddr_valid;
  logic        i_imem_raddr_ready;
  logic [31:0] i_imem_rdata;
  logic        i_imem_rdata_valid;
  logic        o_imem_rdata_ready;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;

  bc_stage_if_prefetch #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC),
    .PC_STEP    (4)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_redirect        (i_redirect),
    .i_redirect_pc     (i_redirect_pc),
    .o_imem_raddr      (o_imem_raddr),
    .o_imem_raddr_valid(o_imem_raddr_valid),
    .i_imem_raddr_ready(i_imem_raddr_ready),
    .i_imem_rdata      (i_imem_rdata),
    .i_imem_rdata_valid(i_imem_rdata_valid),
    .o_imem_rdata_ready(o_imem_rdata_ready),
    .o_instr_valid     (o_instr_valid),
    .o_instr           (o_instr),
    .o_instr_pc        (o_instr_pc),
    .i_instr_ready     (i_instr_ready)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // memory model: each request remembers the fetch epoch it was issued in
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [63:0] exp_q[$];   // {pc, instr} expected at the decode port, in order
  logic [31:0] exp_pc;
  int          epoch;
  int          cyc;
  int          lat_min;
  int          lat_max;
  int          issue_cnt;
  int          n_chk;
  int          n_pass;

  logic        s_rv, s_iv;
  logic [31:0] s_raddr, s_ipc, s_instr;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        irdy;
    logic        exp_rv;
    logic [31:0] exp_raddr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // one clock cycle: drive, sample, compare with model, advance model
  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic rdy, input logic irdy);
    logic        resp;
    logic        exp_rv;
    logic [63:0] h;
    mreq_t       m;
    @(negedge i_clk);
    i_rst              = rst;
    i_redirect         = redir;
    i_redirect_pc      = rpc;
    i_imem_raddr_ready = rdy;
    i_instr_ready      = irdy;
    resp               = (memq.size() > 0) && (memq[0].due <= cyc);
    i_imem_rdata_valid = resp;
    i_imem_rdata       = resp ? memq[0].instr : 32'h0;
    #1;
    s_rv    = o_imem_raddr_valid;
    s_raddr = o_imem_raddr;
    s_iv    = o_instr_valid;
    s_ipc   = o_instr_pc;
    s_instr = o_instr;

    exp_rv = !rst && !redir && ((memq.size() + exp_q.size()) < DEPTH);
    chk("raddr_valid", {31'b0, s_rv}, {31'b0, exp_rv});
    if (!rst) chk("raddr", s_raddr, exp_pc);
    chk("instr_valid", {31'b0, s_iv}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("instr_pc", s_ipc, h[63:32]);
      chk("instr", s_instr, h[31:0]);
    end

    if (rst) begin
      memq.delete();
      exp_q.delete();
      exp_pc = RESET_PC;
      epoch++;
    end else if (redir) begin
      if (resp) m = memq.pop_front();
      exp_q.delete();
      epoch++;
      exp_pc = rpc;
    end else begin
      if (irdy && exp_q.size() != 0) h = exp_q.pop_front();
      if (resp) begin
        m = memq.pop_front();
        if (m.epoch == epoch) exp_q.push_back({m.pc, m.instr});
      end
      if (s_rv && rdy) begin
        issue_cnt++;
        m.pc    = exp_pc;
        m.instr = $urandom;
        m.epoch = epoch;
        m.due   = cyc + int'($urandom_range(lat_max, lat_min));
        memq.push_back(m);
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    logic        seen;
    logic [31:0] r;
    logic        rst_r, redir_r;
    logic [31:0] rpc_r;

    n_chk = 0; n_pass = 0; cyc = 0; epoch = 0; issue_cnt = 0;
    lat_min = 1; lat_max = 1;
    exp_pc = RESET_PC;
    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
    i_imem_raddr_ready = 1'b0; i_imem_rdata = '0; i_imem_rdata_valid = 1'b0;
    i_instr_ready = 1'b0;
    repeat (2) @(posedge i_clk);

    // directed table: sequential fetch, then redirect coinciding with response and pop
    vecs[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h4};
    vecs[4] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h10,  1'b1, 32'h8};
    vecs[5] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100};

    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, vecs[i].redir, vecs[i].rpc, 1'b1, vecs[i].irdy);
      chk("vec_raddr_valid", {31'b0, s_rv}, {31'b0, vecs[i].exp_rv});
      chk("vec_raddr", s_raddr, vecs[i].exp_raddr);
      chk("vec_instr_valid", {31'b0, s_iv}, {31'b0, vecs[i].exp_iv});
      if (vecs[i].exp_iv) chk("vec_instr_pc", s_ipc, vecs[i].exp_ipc);
    end

    // decode stalled: credit limits issue to DEPTH, then releasing restarts it
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue_cnt = 0;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("credit_issue_cnt", issue_cnt, DEPTH);
    chk("credit_stall_rv", {31'b0, s_rv}, 32'h0);
    chk("credit_head_pc", s_ipc, RESET_PC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("credit_restart_rv", {31'b0, s_rv}, 32'h1);

    // three in flight at redirect: stale responses never reach decode
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    lat_min = 4; lat_max = 4;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (s_iv) begin
        seen = 1'b1;
        chk("redir_first_pc", s_ipc, 32'h100);
      end
    end
    chk("redir_first_valid", {31'b0, s_iv}, 32'h1);

    // address wrap, then reset mid-burst
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_raddr0", s_raddr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_raddr1", s_raddr, 32'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("rst_instr_valid", {31'b0, s_iv}, 32'h0);
    chk("rst_raddr", s_raddr, RESET_PC);
    chk("rdata_ready", {31'b0, o_imem_rdata_ready}, 32'h1);

    // randomized run: memory stalls, variable latency, decode back-pressure, redirects, resets
    lat_min = 1; lat_max = 4;
    for (int n = 0; n < 3000; n++) begin
      r       = $urandom;
      rst_r   = ($urandom_range(299, 0) == 0);
      redir_r = ($urandom_range(24, 0) == 0);
      rpc_r   = ($urandom_range(2, 0) == 0) ? {28'hFFFF_FFF, r[3:2], 2'b00}
                                            : {r[31:2], 2'b00};
      step(rst_r, redir_r, rpc_r, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
